// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detector self-test sequencer.
// Contents:
//   state_t          - sequencer FSM state encoding
//   DET_RESET_ACTIVE - level that holds the detector in reset
//   idx_width()      - width of the bit_idx output for a given pattern length
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic DET_RESET_ACTIVE = 1'b1;

  // bit_idx must be able to hold the value pat_w (all bits driven).
  function automatic int idx_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_hit_counter.sv
// Saturating hit counter for one sequencer run.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-low reset (count -> 0)
//   clr    - zero the count at the next edge (wins over en)
//   en     - add one at the next edge unless already at the maximum
//   total  - the count as it will be after this edge, i.e. the registered
//            count plus this cycle's clr/en effect; lets the owner capture
//            a final result that includes the current cycle's hit
module seq_det_hit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] total
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count;

  always_comb begin
    total = count;
    if (clr) begin
      total = '0;
    end else if (en && (count != CNT_MAX)) begin
      total = count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= total;
    end
  end

endmodule

// File: rtl/seq_det_sequencer.sv
// Self-test sequencer for one Moore sequence detector.
// Captures a parallel pattern on start, holds the detector in reset for
// CLR_CYC clocks, shifts the pattern out on ain one bit per clock, counts
// the clocks in which the detector reports a hit, and reports the count
// with a one-cycle done pulse.
// Ports:
//   sys_clock  - system clock, rising edge
//   reset      - synchronous, active-low block reset
//   start      - run request, only honoured in IDLE
//   abort      - cancel a run (also masks start in IDLE)
//   pattern    - test pattern, captured when start is accepted
//   ready      - high in IDLE
//   det_reset  - active-high reset to the detector
//   ain        - serial bit to the detector
//   detected   - Moore output of the detector
//   busy       - high in CLEAR, SHIFT, DRAIN
//   done       - one-cycle pulse when a run completes
//   hits       - hit count of the last completed run
//   bit_idx    - number of pattern bits driven so far in this run
//   dbg_state  - current FSM state, for checkers
// Handshake: start is a request sampled only while ready=1; it is accepted
// at the edge where ready=1, start=1, abort=0, and the run's completion is
// signalled by done. There is no backpressure on done/hits.
module seq_det_sequencer
  import seq_det_pkg::*;
#(
  parameter int  PAT_W     = 16,
  parameter int  CNT_W     = 4,
  parameter int  CLR_CYC   = 2,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int IDX_W     = idx_width(PAT_W)
) (
  input  logic             sys_clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  output logic             ready,
  output logic             det_reset,
  output logic             ain,
  input  logic             detected,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hits,
  output logic [IDX_W-1:0] bit_idx,
  output state_t           dbg_state
);

  localparam int              CLR_W    = $clog2(CLR_CYC + 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);

  state_t           state, state_nxt;
  logic [PAT_W-1:0] sreg, sreg_shifted;
  logic [CLR_W-1:0] clr_cnt;
  logic             accept, abort_hit, sample, next_bit;
  logic             ain_d, det_reset_d, done_d;
  logic [CNT_W-1:0] run_total;

  assign ready     = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  assign accept    = (state == IDLE) && start && !abort;
  assign abort_hit = busy && abort;

  assign next_bit     = MSB_FIRST ? sreg[PAT_W-1] : sreg[0];
  assign sreg_shifted = MSB_FIRST ? {sreg[PAT_W-2:0], 1'b0} : {1'b0, sreg[PAT_W-1:1]};

  // The detector registers ain at the end of the cycle it is driven, so the
  // first SHIFT cycle still shows the cleared detector and the DRAIN cycle
  // shows the effect of the last bit.
  assign sample = ((state == SHIFT) && (bit_idx >= IDX_W'(2))) || (state == DRAIN);

  // State register
  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CLEAR;
      CLEAR:   if (abort) state_nxt = IDLE;
               else if (clr_cnt == CLR_LAST) state_nxt = SHIFT;
      SHIFT:   if (abort) state_nxt = IDLE;
               else if (bit_idx == IDX_W'(PAT_W)) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: values the registered outputs take in the next state.
  always_comb begin
    det_reset_d = ~DET_RESET_ACTIVE;
    ain_d       = 1'b0;
    done_d      = 1'b0;
    // An abort clears the detector for the one cycle that follows it.
    if ((state_nxt == CLEAR) || abort_hit) det_reset_d = DET_RESET_ACTIVE;
    if (state_nxt == SHIFT) ain_d = next_bit;
    if ((state == DRAIN) && !abort) done_d = 1'b1;
  end

  // Datapath and registered outputs
  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      sreg      <= '0;
      clr_cnt   <= '0;
      bit_idx   <= '0;
      ain       <= 1'b0;
      det_reset <= DET_RESET_ACTIVE;
      done      <= 1'b0;
      hits      <= '0;
    end else begin
      ain       <= ain_d;
      det_reset <= det_reset_d;
      done      <= done_d;
      if (accept) begin
        sreg    <= pattern;
        bit_idx <= '0;
      end else if (state_nxt == SHIFT) begin
        sreg    <= sreg_shifted;
        bit_idx <= bit_idx + IDX_W'(1);
      end
      clr_cnt <= (state == CLEAR) ? clr_cnt + CLR_W'(1) : '0;
      if (done_d) hits <= run_total;
    end
  end

  seq_det_hit_counter #(
    .CNT_W (CNT_W)
  ) u_hit_counter (
    .clk   (sys_clock),
    .reset (reset),
    .clr   (accept),
    .en    (sample && detected),
    .total (run_total)
  );

endmodule

// File: doc/seq_det_sequencer.md
Name: seq_det_sequencer

Overview:
- Controller that sequences one Moore sequence-detector instance for self-test and demo on the board.
- Accepts a parallel test pattern and clears the detector. Then shifts the pattern serially onto the detector's `ain`, one bit per clock, and counts the clocks in which `detected` is asserted.
- Reports the hit count with a done pulse.
- Sits between a pattern source (switches/loader) and the detector wrapper, and owns the detector's reset and input.

Parameters:
- PAT_W, 16, pattern length in bits (>=2).
- CNT_W, 4, width of hit counter (saturating).
- CLR_CYC, 2, clocks the detector reset is held in CLEAR (>=1).
- MSB_FIRST, 1, 1 = shift pattern[PAT_W-1] first, 0 = pattern[0] first.

Ports:
- sys_clock  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-low block reset.
- start  in  1  request a run. Sampled only in IDLE.
- abort  in  1  cancel a run in progress.
- pattern  in  PAT_W  test pattern, captured on accepted start.
- ready  out  1  high in IDLE: start will be accepted.
- det_reset  out  1  active-high reset to the detector.
- ain  out  1  serial bit to the detector.
- detected  in  1  Moore output of the detector.
- busy  out  1  high in CLEAR, SHIFT, DRAIN.
- done  out  1  one-cycle pulse on run completion.
- hits  out  CNT_W  detection count of the last completed run. Held until the next done.
- bit_idx  out  clog2(PAT_W+1)  number of bits already driven in the current run.

Behaviour:
- Reset (reset=0 at a clock edge) forces these values:
  - state = IDLE, ready = 1
  - det_reset = 1 (the detector stays cleared while this block is in reset)
  - ain = 0, busy = 0, done = 0, hits = 0, bit_idx = 0
  - pattern shift register = 0, clear counter = 0, run counter = 0.
- All outputs are registered. `ready` and `busy` are decoded from the state register.
- IDLE:
  - det_reset = 0, ain = 0.
  - start=1 and abort=0 → capture pattern, zero the run counter, go to CLEAR.
  - start=1 and abort=1 in the same cycle → abort wins: start is ignored, stay in IDLE.
- CLEAR:
  - det_reset = 1, ain = 0, for exactly CLR_CYC clocks. Then go to SHIFT.
- SHIFT:
  - det_reset = 0.
  - Each clock, ain = next pattern bit in MSB_FIRST order and bit_idx increments.
  - Lasts exactly PAT_W clocks, then go to DRAIN.
- Sampling latency: the detector registers ain on the edge ending the cycle it is driven, so detected reflects bit k in the cycle after bit k is driven.
  - `detected` is sampled in SHIFT cycles 2..PAT_W and in the single DRAIN cycle.
  - This gives exactly PAT_W samples. The first SHIFT cycle is not sampled (it reflects the cleared state).
- Hit counting:
  - Each sample with detected=1 increments the run counter.
  - The counter saturates at 2^CNT_W-1 and never wraps.
- DRAIN:
  - ain = 0, one clock.
  - At its end, hits ← final run counter (including this cycle's sample), done = 1 for one cycle, go to IDLE.
- Abort:
  - abort=1 in CLEAR, SHIFT or DRAIN → next state IDLE, det_reset = 1 for that one following cycle, ain = 0.
  - done is not pulsed and hits keeps its previous value.
- start asserted while busy is ignored. No queuing.
- `pattern` changes after acceptance have no effect on the running pattern.
- Back-to-back runs: start may be asserted in the cycle done is high (state already IDLE). The new run begins with CLEAR.
- A mid-run reset (reset=0) overrides everything, including abort, and applies the full reset values the next cycle.

Decomposition:
- Shared package seq_det_pkg:
  - state enum: IDLE=0, CLEAR=1, SHIFT=2, DRAIN=3.
  - function for the bit_idx width.
  - constant DET_RESET_ACTIVE=1'b1.
- One natural sub-module: seq_det_hit_counter (CNT_W saturating counter with clear and enable).
- The FSM, shift register and bit counter stay in the top module.

Test Plan:
- All scenarios use a bench stub detector: Moore, "two consecutive 1s", active-high reset.
- Reset: hold reset=0 for 3 clocks → ready=1, det_reset=1, ain=0, hits=0, done=0. Release → det_reset=0 next cycle.
- Pattern 16'h0006, MSB_FIRST=1:
  - det_reset=1 for exactly 2 clocks after start.
  - ain sequence 0000_0000_0000_0110 over 16 clocks.
  - done 19 clocks after start was accepted. hits=1.
- Pattern 16'hFFFF, CNT_W=4 → hits=15. Repeat with CNT_W=3 → hits=7 (saturated, no wrap).
- Abort in the 5th SHIFT cycle:
  - next cycle state IDLE, det_reset=1 for 1 clock.
  - no done pulse, hits unchanged from the previous run.
  - start asserted in the same cycle as an abort in IDLE is ignored.
- Start held high during a run, and pattern changed mid-run:
  - only one done pulse for that run.
  - ain follows the originally captured pattern.
  - a second start in the done cycle launches a new run with a fresh CLEAR.
- MSB_FIRST=0, pattern 16'h0003 → first two ain bits are 1,1, and hits=1.
